// File: rtl/gcd_req_seq_pkg.sv
// Shared types and widths for the GCD request sequencer and core.
// Package name gcd_pkg is shared with the GCD core.
package gcd_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TAG_WIDTH  = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [TAG_WIDTH-1:0]  tag;
  } gcd_req_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    START,
    BUSY,
    RESP
  } gcd_seq_state_e;

endpackage

// File: rtl/gcd_req_seq_if.sv
// Request/response valid-ready bundle of the GCD sequencer.
// master = requester, slave = sequencer.
interface gcd_req_seq_if;
  import gcd_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_gcd;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_gcd, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_gcd, rsp_tag, rsp_err
  );

endinterface

// File: rtl/gcd_req_seq_watchdog.sv
// BUSY-cycle watchdog: cleared before BUSY, counts BUSY cycles,
// expire_o high on the last allowed cycle.
module gcd_seq_watchdog #(
  parameter int CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  assign expire_o = en_i && (cnt_q == CW'(CYCLES - 1));

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gcd_req_seq.sv
// Front-end sequencer for the GCD core: request in, core drive, response out.
// Optional BUSY timeout enabled by defining GCD_SEQ_TIMEOUT_EN.
module gcd_req_seq
  import gcd_pkg::*;
#(
  parameter int TAG_WIDTH      = gcd_pkg::TAG_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_gcd_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  core_nreset_o,
  output logic                  core_enable_o,
  output logic [DATA_WIDTH-1:0] core_operand_a_o,
  output logic [DATA_WIDTH-1:0] core_operand_b_o,
  input  logic [DATA_WIDTH-1:0] core_gcd_i,
  input  logic                  core_done_i
);

  gcd_seq_state_e        state_q, state_d;
  gcd_req_t              req_q, req_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] gcd_q, gcd_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;
  logic                  nreset_q, nreset_d;
  logic                  enable_q, enable_d;
  logic                  expire;

`ifdef GCD_SEQ_TIMEOUT_EN
  gcd_seq_watchdog #(
    .CYCLES   (TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == START),
    .en_i     (state_q == BUSY),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tag_d   = tag_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_d.a   = req_a_i;
          req_d.b   = req_b_i;
          req_d.tag = '0;
          tag_d     = req_tag_i;
          state_d   = CLR;
        end
      end
      CLR:   state_d = START;
      START: state_d = BUSY;
      BUSY: begin
        if (core_done_i) begin
          gcd_d   = core_gcd_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expire) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
    nreset_d    = (state_d != CLR);
    enable_d    = (state_d == START) || (state_d == BUSY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_q       <= '0;
      tag_q       <= '0;
      gcd_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      nreset_q    <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      tag_q       <= tag_d;
      gcd_q       <= gcd_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      nreset_q    <= nreset_d;
      enable_q    <= enable_d;
    end
  end

  assign req_ready_o      = req_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_gcd_o        = gcd_q;
  assign rsp_tag_o        = tag_q;
  assign rsp_err_o        = err_q;
  assign busy_o           = busy_q;
  assign core_nreset_o    = nreset_q;
  assign core_enable_o    = enable_q;
  assign core_operand_a_o = req_q.a;
  assign core_operand_b_o = req_q.b;

endmodule

// File: tb/tb_gcd_req_seq.sv
// Directed bench for gcd_req_seq with a behavioural Euclid core.
module tb_gcd_req_seq;
  import gcd_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  busy;
  logic                  core_nreset;
  logic                  core_enable;
  logic [DATA_WIDTH-1:0] core_a;
  logic [DATA_WIDTH-1:0] core_b;
  logic [DATA_WIDTH-1:0] core_gcd;
  logic                  core_done;

  logic [DATA_WIDTH-1:0] mx, my;
  logic                  mloaded, mdone;
  logic                  stuck;

  int checks = 0;
  int errors = 0;

  gcd_req_seq_if bus ();

  gcd_req_seq #(
    .TIMEOUT_CYCLES   (8)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (bus.req_valid),
    .req_ready_o      (bus.req_ready),
    .req_a_i          (bus.req_a),
    .req_b_i          (bus.req_b),
    .req_tag_i        (bus.req_tag),
    .rsp_valid_o      (bus.rsp_valid),
    .rsp_ready_i      (bus.rsp_ready),
    .rsp_gcd_o        (bus.rsp_gcd),
    .rsp_tag_o        (bus.rsp_tag),
    .rsp_err_o        (bus.rsp_err),
    .busy_o           (busy),
    .core_nreset_o    (core_nreset),
    .core_enable_o    (core_enable),
    .core_operand_a_o (core_a),
    .core_operand_b_o (core_b),
    .core_gcd_i       (core_gcd),
    .core_done_i      (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Euclid core model: async active-low reset, sticky done
  always @(posedge clk or negedge core_nreset) begin
    if (!core_nreset) begin
      mx <= '0; my <= '0; mloaded <= 1'b0; mdone <= 1'b0;
    end else if (core_enable && !mdone) begin
      if (!mloaded) begin
        mx <= core_a; my <= core_b; mloaded <= 1'b1;
      end else if (my == '0) begin
        mdone <= 1'b1;
      end else begin
        mx <= my; my <= mx % my;
      end
    end
  end

  assign core_gcd  = mx;
  assign core_done = stuck ? 1'b0 : mdone;

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag);
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    step();
    bus.req_valid = 1'b0;
    chk("nreset_clr", 32'(core_nreset), 0);
    chk("busy_clr", 32'(busy), 1);
    chk("ready_clr", 32'(bus.req_ready), 0);
    step();
    chk("nreset_start", 32'(core_nreset), 1);
    chk("enable_start", 32'(core_enable), 1);
  endtask

  task automatic wait_rsp(input int budget, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < budget) begin
      step();
      lat++;
    end
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 1);
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 0);
    chk("busy_drop", 32'(busy), 0);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] tag, input logic [15:0] g,
                     input int exp_lat);
    int lat;
    send(a, b, tag);
    wait_rsp(100, lat);
    if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_gcd", 32'(bus.rsp_gcd), 32'(g));
    chk("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
    chk("rsp_err", 32'(bus.rsp_err), 0);
    ack();
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1;
    stuck = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b0;
    step(); step();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_nreset", 32'(core_nreset), 0);
    chk("rst_enable", 32'(core_enable), 0);
    chk("rst_op_a", 32'(core_a), 0);
    rst = 1'b0;
    step();
    chk("post_rst_nreset", 32'(core_nreset), 1);
    chk("post_rst_ready", 32'(bus.req_ready), 1);

    run(16'd48, 16'd18, 4'd3, 16'd6, 6);
    run(16'd35, 16'd14, 4'd4, 16'd7, 5);
    run(16'd0, 16'd7, 4'd1, 16'd7, 4);
    run(16'd9, 16'd9, 4'd2, 16'd9, 4);

    send(16'd48, 16'd18, 4'd5);
    wait_rsp(100, lat);
    bus.req_valid = 1'b1;
    bus.req_a = 16'd100; bus.req_b = 16'd10; bus.req_tag = 4'd9;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_gcd", 32'(bus.rsp_gcd), 6);
      chk("bp_tag", 32'(bus.rsp_tag), 5);
      chk("bp_ready", 32'(bus.req_ready), 0);
      chk("bp_enable", 32'(core_enable), 0);
      chk("bp_op_a", 32'(core_a), 48);
    end
    bus.req_valid = 1'b0;
    ack();
    step();

    send(16'd100, 16'd75, 4'd2);
    step(); step();
    chk("busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_nreset", 32'(core_nreset), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 0);
    chk("idle_after_rst", 32'(bus.req_ready), 1);

    stuck = 1'b1;
    send(16'd12, 16'd8, 4'd6);
`ifdef GCD_SEQ_TIMEOUT_EN
    wait_rsp(100, lat);
    chk("to_latency", 32'(lat), 9);
    chk("to_err", 32'(bus.rsp_err), 1);
    chk("to_gcd", 32'(bus.rsp_gcd), 0);
    chk("to_tag", 32'(bus.rsp_tag), 6);
    ack();
    stuck = 1'b0;
    step();
`else
    for (int i = 0; i < 30; i++) step();
    chk("hang_valid", 32'(bus.rsp_valid), 0);
    chk("hang_busy", 32'(busy), 1);
    chk("hang_enable", 32'(core_enable), 1);
    stuck = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif
    run(16'd21, 16'd6, 4'd7, 16'd3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
